// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage.
// Answers each access after LATENCY cycles and stalls the pipe meanwhile.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] D_MEM_ADDR,
  input  logic        D_MEM_WEN,
  input  logic [3:0]  D_MEM_BE,
  input  logic [31:0] D_MEM_DOUT,
  output logic [31:0] D_MEM_DI,
  output logic        RESP_VALID,
  output logic        ERR,
  output logic        STALL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            off_q;
  logic                  wen_q;
  logic [3:0]            be_q;
  logic [31:0]           wdat_q;

  logic [31:0] di_q, di_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  to_resp;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [1:0]            r_off;
  logic                  r_wen;
  logic [3:0]            r_be;
  logic [31:0]           bmask;
  logic                  unused_addr;

  assign unused_addr = ^D_MEM_ADDR[31:ADDR_WIDTH+2];

  assign accept = (state_q == IDLE) && REQ_VALID && (|D_MEM_BE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY  = (state_q == IDLE);
    RESP_VALID = (state_q == RESP);
    STALL      = accept || (state_q == WAIT);
    D_MEM_DI   = di_q;
    ERR        = err_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx_q  <= '0;
      off_q  <= '0;
      wen_q  <= 1'b0;
      be_q   <= '0;
      wdat_q <= '0;
    end else if (accept) begin
      idx_q  <= D_MEM_ADDR[ADDR_WIDTH+1:2];
      off_q  <= D_MEM_ADDR[1:0];
      wen_q  <= D_MEM_WEN;
      be_q   <= D_MEM_BE;
      wdat_q <= D_MEM_DOUT;
    end
  end

  // With LATENCY==1 the response is built straight from the inputs.
  always_comb begin
    if (state_q == IDLE) begin
      r_idx = D_MEM_ADDR[ADDR_WIDTH+1:2];
      r_off = D_MEM_ADDR[1:0];
      r_wen = D_MEM_WEN;
      r_be  = D_MEM_BE;
    end else begin
      r_idx = idx_q;
      r_off = off_q;
      r_wen = wen_q;
      r_be  = be_q;
    end
  end

  assign to_resp = (state_d == RESP) && (state_q != RESP);
  assign bmask = {{8{r_be[3]}}, {8{r_be[2]}},
                  {8{r_be[1]}}, {8{r_be[0]}}};

  always_comb begin
    di_d  = '0;
    err_d = 1'b0;
    if (to_resp) begin
      err_d = |r_off;
      if (r_wen && !(|r_off)) di_d = mem[r_idx] & bmask;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      di_q  <= '0;
      err_q <= 1'b0;
    end else begin
      di_q  <= di_d;
      err_q <= err_d;
    end
  end

  // Array is not reset; a store commits on the edge leaving RESP.
  always_ff @(posedge CLK) begin
    if (state_q == RESP && !wen_q && off_q == 2'b00) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Three instances (LATENCY 1, 2, 15) share one request stream.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        D_MEM_WEN = 1'b1;
  logic [31:0] D_MEM_ADDR = '0;
  logic [31:0] D_MEM_DOUT = '0;
  logic [3:0]  D_MEM_BE = '0;

  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic        st  [3];
  logic [31:0] di  [3];

  int checks = 0;
  int failures = 0;

  int          lat    [3];
  logic [31:0] got_di [3];
  logic        got_er [3];
  int          stalls;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 15))
    ) u_dut (
      .CLK(CLK),
      .RSTn(RSTn),
      .REQ_VALID(REQ_VALID),
      .REQ_READY(rdy[g]),
      .D_MEM_ADDR(D_MEM_ADDR),
      .D_MEM_WEN(D_MEM_WEN),
      .D_MEM_BE(D_MEM_BE),
      .D_MEM_DOUT(D_MEM_DOUT),
      .D_MEM_DI(di[g]),
      .RESP_VALID(rv[g]),
      .ERR(er[g]),
      .STALL(st[g])
    );
  end

  function automatic int lt(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 15);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse; records each instance's response.
  task automatic access(input logic [31:0] a, input logic w,
                        input logic [3:0] be, input logic [31:0] d);
    D_MEM_ADDR = a;
    D_MEM_WEN  = w;
    D_MEM_BE   = be;
    D_MEM_DOUT = d;
    REQ_VALID  = 1'b1;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      got_di[k] = '0;
      got_er[k] = 1'b0;
    end
    @(negedge CLK);
    if (st[1]) stalls++;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    D_MEM_BE  = 4'b0000;
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK);
      if (st[1]) stalls++;
      for (int k = 0; k < 3; k++) begin
        if (rv[k] && lat[k] == 0) begin
          lat[k] = c;
          got_di[k] = di[k];
          got_er[k] = er[k];
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_resp(string tag, logic [31:0] edi, logic eer);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_lat%0d", tag, k), lat[k], lt(k));
      chk($sformatf("%s_di%0d", tag, k), got_di[k], edi);
      chk($sformatf("%s_err%0d", tag, k), {31'd0, got_er[k]}, {31'd0, eer});
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("rst_rv", {31'd0, rv[1]}, 32'd0);
    chk("rst_err", {31'd0, er[1]}, 32'd0);
    chk("rst_di", di[1], 32'd0);
    chk("rst_stall", {31'd0, st[1]}, 32'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    access(32'h10, 1'b0, 4'b1111, 32'h1234_5678);
    expect_resp("pre10", 32'h0, 1'b0);

    // Reset while a store is waiting
    D_MEM_ADDR = 32'h10;
    D_MEM_WEN  = 1'b0;
    D_MEM_BE   = 4'b1111;
    D_MEM_DOUT = 32'hFFFF_FFFF;
    REQ_VALID  = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    D_MEM_BE  = 4'b0000;
    chk("midwait_stall", {31'd0, st[1]}, 32'd1);
    chk("midwait_ready", {31'd0, rdy[1]}, 32'd0);
    #2;
    RSTn = 1'b0;
    #1;
    chk("arst_stall", {31'd0, st[1]}, 32'd0);
    chk("arst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("arst_rv0", {31'd0, rv[0]}, 32'd0);
    chk("arst_stall15", {31'd0, st[2]}, 32'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    access(32'h10, 1'b1, 4'b1111, 32'h0);
    expect_resp("rst_keep", 32'h1234_5678, 1'b0);

    // Store then load, latency sweep
    access(32'h40, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    expect_resp("st40", 32'h0, 1'b0);
    chk("st40_stalls", stalls, 32'd2);
    access(32'h40, 1'b1, 4'b1111, 32'h0);
    expect_resp("ld40", 32'hDEAD_BEEF, 1'b0);

    // Partial store
    access(32'h80, 1'b0, 4'b1111, 32'h1122_3344);
    access(32'h80, 1'b0, 4'b0101, 32'hAABB_CCDD);
    expect_resp("pst80", 32'h0, 1'b0);
    access(32'h80, 1'b1, 4'b1111, 32'h0);
    expect_resp("ld80", 32'h11BB_33DD, 1'b0);
    access(32'h80, 1'b1, 4'b0011, 32'h0);
    expect_resp("ld80_lo", 32'h0000_33DD, 1'b0);

    // Misaligned
    access(32'h42, 1'b1, 4'b1111, 32'h0);
    expect_resp("mis_ld42", 32'h0, 1'b1);
    access(32'h43, 1'b0, 4'b1111, 32'h0000_0000);
    expect_resp("mis_st43", 32'h0, 1'b1);
    access(32'h40, 1'b1, 4'b1111, 32'h0);
    expect_resp("ld40_after", 32'hDEAD_BEEF, 1'b0);

    // Bubbles
    REQ_VALID = 1'b1;
    D_MEM_BE  = 4'b0000;
    D_MEM_ADDR = 32'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("bub_ready%0d", c), {31'd0, rdy[1]}, 32'd1);
      chk($sformatf("bub_stall%0d", c), {31'd0, st[1]}, 32'd0);
      chk($sformatf("bub_rv%0d", c), {31'd0, rv[0] | rv[1] | rv[2]}, 32'd0);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;

    // Address wrap
    access(32'h1004, 1'b0, 4'b1111, 32'h5A5A_5A5A);
    access(32'h0004, 1'b1, 4'b1111, 32'h0);
    expect_resp("wrap", 32'h5A5A_5A5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the pipelined RV32I core. It is the memory-side end of the interface the control unit drives: address, active-low write enable, byte enables and write data.
- Holds the data array and answers each access after a fixed, parameterised latency. While an access is outstanding it raises STALL so the pipeline freezes.
- Replaces the ideal zero-latency data memory and supports multi-cycle memory experiments.

Parameters:
- ADDR_WIDTH, 10, word-index width; array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from accept to response, inclusive of the response cycle; legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RSTn  input  1  asynchronous active-low reset
- REQ_VALID  input  1  MEM stage presents an instruction this cycle
- REQ_READY  output  1  responder can accept a request this cycle
- D_MEM_ADDR  input  32  byte address; word index = D_MEM_ADDR[ADDR_WIDTH+1:2]
- D_MEM_WEN  input  1  active-low write enable (0 = store, 1 = load)
- D_MEM_BE  input  4  byte enables; 4'b0000 = not a memory access
- D_MEM_DOUT  input  32  store data from core
- D_MEM_DI  output  32  load data to core; valid only while RESP_VALID=1
- RESP_VALID  output  1  one-cycle response strobe
- ERR  output  1  misaligned access; qualified by RESP_VALID
- STALL  output  1  freeze request to pipeline

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE, countdown=0, RESP_VALID=0, ERR=0, D_MEM_DI=0, captured request registers cleared. Array contents are not reset.
- Reset mid-operation: a pending access is dropped and a pending store is not written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - REQ_READY=1.
  - Accept occurs when REQ_VALID=1 and D_MEM_BE!=0. On accept, capture ADDR, WEN, BE and DOUT, and load countdown=LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
  - REQ_VALID with BE=0 is a bubble: ignored, no state change, no STALL.
- WAIT:
  - REQ_READY=0.
  - Countdown decrements each edge; when countdown reaches 1, next state is RESP.
  - Inputs are ignored; captured values are used.
- RESP:
  - REQ_READY=0, RESP_VALID=1 for exactly one cycle; next state is IDLE.
  - D_MEM_DI and ERR are registered on the edge entering RESP.
- Timing: accept at edge t gives RESP_VALID high in the cycle after edge t+LATENCY-1. Earliest next accept is at edge t+LATENCY+1, so there is one IDLE cycle between accesses.
- Load (WEN=1): D_MEM_DI = array word with bytes whose BE bit is 0 forced to 0. Sign/zero extension is the core's job.
- Store (WEN=0): at the edge leaving RESP, only bytes with BE bit 1 are updated from captured DOUT. D_MEM_DI=0.
- Read-after-write: a load accepted after a store's RESP sees the new data.
- Misaligned: captured ADDR[1:0]!=0 gives ERR=1 with RESP_VALID, D_MEM_DI=0, no array update. Same latency as a normal access.
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so 0x0000_1000 aliases 0x0000_0000 for ADDR_WIDTH=10.
- STALL is combinational: 1 when (IDLE and REQ_VALID and BE!=0) or WAIT; 0 in RESP and for bubbles. The core holds MEM-stage inputs stable while STALL=1.

Test Plan:
- Reset and idle: RSTn low mid-WAIT of a store to 0x10 with LATENCY=2 -> outputs immediately 0 and IDLE; later load of 0x10 returns previous contents.
- Store then load, LATENCY=2: store 0xDEADBEEF to 0x40 with BE=1111 accepted at edge t -> RESP_VALID at cycle t+1→t+2, STALL high 2 cycles. Load from 0x40 accepted at edge t+3 -> D_MEM_DI=0xDEADBEEF with RESP_VALID at t+4→t+5.
- Partial store: word 0x11223344 at 0x80; store 0xAABBCCDD with BE=0101 -> subsequent BE=1111 load returns 0x11BB33DD. Load with BE=0011 returns 0x000033DD.
- Misaligned: load at 0x42 -> ERR=1, D_MEM_DI=0, RESP_VALID after LATENCY. Store at 0x43 leaves word 0x40 unchanged.
- Bubbles and latency sweep: REQ_VALID=1, BE=0 for 5 cycles -> REQ_READY=1, STALL=0, no RESP_VALID. Repeat the store/load test with LATENCY=1 and 15 -> response exactly LATENCY cycles after accept.
- Wrap: store 0x5A5A5A5A at 0x1004 (ADDR_WIDTH=10) -> load from 0x0004 returns 0x5A5A5A5A.
